// File: rtl/wc_f22x2_conv.sv
// Fixed-coefficient 4-tap 1-D convolution as two Winograd F(2,2) tiles in a 4-stage pipeline.
// Define WC_SAT_EN to saturate the outputs to DW bits instead of wrapping.

module wc_f22x2_tile #(
  parameter int DW = 10,
  parameter int WW = 6,
  parameter int GA = 4,
  parameter int GB = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [DW-1:0]   a0_i,
  input  logic signed [DW-1:0]   a1_i,
  input  logic signed [DW-1:0]   a2_i,
  output logic signed [DW+WW+2:0] y0_o,
  output logic signed [DW+WW+2:0] y1_o
);
  localparam int PW = DW + WW + 2;
  localparam logic signed [WW-1:0] GA_C = WW'(GA);
  localparam logic signed [WW-1:0] GB_C = WW'(GB);
  localparam logic signed [WW:0]   GS_C = (WW+1)'(GA + GB);

  logic signed [DW:0]   df1_d, df3_d, df1_q, df3_q;
  logic signed [DW-1:0] a1_q;
  logic signed [PW-1:0] m1_d, m2_d, m3_d, m1_q, m2_q, m3_q;

  always_comb begin
    df1_d = (DW+1)'(a0_i) - (DW+1)'(a1_i);
    df3_d = (DW+1)'(a2_i) - (DW+1)'(a1_i);
    m1_d  = PW'(df1_q) * PW'(GA_C);
    m2_d  = PW'(a1_q)  * PW'(GS_C);
    m3_d  = PW'(df3_q) * PW'(GB_C);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      df1_q <= '0;
      df3_q <= '0;
      a1_q  <= '0;
      m1_q  <= '0;
      m2_q  <= '0;
      m3_q  <= '0;
    end else begin
      df1_q <= df1_d;
      df3_q <= df3_d;
      a1_q  <= a1_i;
      m1_q  <= m1_d;
      m2_q  <= m2_d;
      m3_q  <= m3_d;
    end
  end

  // Output transform stays combinational; the top folds it into the final stage.
  assign y0_o = (PW+1)'(m1_q) + (PW+1)'(m2_q);
  assign y1_o = (PW+1)'(m2_q) + (PW+1)'(m3_q);
endmodule

module wc_f22x2_conv #(
  parameter int DW = 10,
  parameter int WW = 6,
  parameter int W0 = 4,
  parameter int W1 = 2,
  parameter int W2 = 13,
  parameter int W3 = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5*DW-1:0]   D,
  output logic [2*DW-1:0]   Z
);
  localparam int TW = DW + WW + 3;
  localparam int SW = DW + WW + 4;

  logic [5*DW-1:0]     d_q;
  logic [4:0][DW-1:0]  win;
  logic [1:0][TW-1:0]  ty0, ty1;
  logic signed [SW-1:0] s0, s1;
  logic [2*DW-1:0]     z_d, z_q;

  // win[i] is sample d_i; d0 sits in the top slice of D.
  for (genvar i = 0; i < 5; i++) begin : g_win
    assign win[i] = d_q[(5-i)*DW-1 -: DW];
  end

  for (genvar t = 0; t < 2; t++) begin : g_tile
    wc_f22x2_tile #(
      .DW(DW), .WW(WW),
      .GA(t == 0 ? W0 : W2),
      .GB(t == 0 ? W1 : W3)
    ) u_tile (
      .clk  (clk),
      .rst  (rst),
      .a0_i ($signed(win[2*t])),
      .a1_i ($signed(win[2*t+1])),
      .a2_i ($signed(win[2*t+2])),
      .y0_o (ty0[t]),
      .y1_o (ty1[t])
    );
  end

  function automatic logic [DW-1:0] narrow(input logic signed [SW-1:0] s);
`ifdef WC_SAT_EN
    logic signed [SW-1:0] smax, smin;
    smax = SW'(2**(DW-1) - 1);
    smin = -smax - SW'(1);
    if (s > smax)      return smax[DW-1:0];
    else if (s < smin) return smin[DW-1:0];
    else               return s[DW-1:0];
`else
    return s[DW-1:0];
`endif
  endfunction

  always_comb begin
    s0  = SW'($signed(ty0[0])) + SW'($signed(ty0[1]));
    s1  = SW'($signed(ty1[0])) + SW'($signed(ty1[1]));
    z_d = {narrow(s0), narrow(s1)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q <= '0;
      z_q <= '0;
    end else begin
      d_q <= D;
      z_q <= z_d;
    end
  end

  assign Z = z_q;
endmodule

// File: tb/tb_wc_f22x2_conv.sv
// Scoreboard bench for wc_f22x2_conv: driver queues hand-computed results, monitor pops them 4 edges later.
module tb_wc_f22x2_conv;
  localparam int DW = 10;
`ifdef WC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [5*DW-1:0] D   = '0;
  logic [2*DW-1:0] Z;

  int n_chk = 0, n_pass = 0;
  int push_cnt = 0, seen_cnt = 0, since = 0;
  logic [3:0] vld = '0;
  logic [2*DW-1:0] exp_q[$];

  wc_f22x2_conv dut (.clk(clk), .rst(rst), .D(D), .Z(Z));

  always #5 clk = ~clk;

  function automatic logic [2*DW-1:0] pk2(input int a, input int b);
    logic [DW-1:0] x, y;
    x = DW'(a);
    y = DW'(b);
    return {x, y};
  endfunction

  task automatic check(input string nm, input logic [2*DW-1:0] got, input logic [2*DW-1:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got y0=%0d y1=%0d (%b), want y0=%0d y1=%0d (%b)", nm,
                  $signed(got[2*DW-1:DW]), $signed(got[DW-1:0]), got,
                  $signed(want[2*DW-1:DW]), $signed(want[DW-1:0]), want);
  endtask

  // One window per call, one cycle each; rel releases reset on the same edge.
  task automatic apply(input int d0, input int d1, input int d2, input int d3, input int d4,
                       input int y0, input int y1, input bit rel = 1'b0);
    int dv[5];
    dv = '{d0, d1, d2, d3, d4};
    @(negedge clk);
    if (rel) rst = 1'b1;
    for (int i = 0; i < 5; i++) D[(5-i)*DW-1 -: DW] = DW'(dv[i]);
    exp_q.push_back(pk2(y0, y1));
    push_cnt++;
  endtask

  // Tag which edges sampled a fresh window; the tag reaches vld[3] when its result is on Z.
  always @(posedge clk) begin
    if (!rst) begin
      vld      = '0;
      since    = 0;
      seen_cnt = push_cnt;
    end else begin
      vld      = {vld[2:0], push_cnt != seen_cnt};
      seen_cnt = push_cnt;
      since++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (vld[3]) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL scoreboard_underflow: got Z=%b, want a queued result", Z);
        end else begin
          check("result", Z, exp_q.pop_front());
        end
      end else if (since >= 1 && since <= 3) begin
        check("flush_zero", Z, '0);
      end
    end
  end

  initial begin
    #1 check("reset_state", Z, '0);
    repeat (2) @(posedge clk);

    apply(2, -10, 3, 4, -13, 63, -99, 1'b1);
    repeat (3) apply(2, -10, 3, 4, -13, 63, -99);
    repeat (2) apply(-19, -6, 3, -9, -12, -130, -243);

    apply(1, 0, 0, 0, 0, 4, 0);
    apply(0, 0, 0, 0, 1, 0, 9);
    apply(0, 1, 0, 0, 0, 2, 4);
    apply(0, 0, 1, 0, 0, 13, 2);
    apply(0, 0, 0, 1, 0, 9, 13);
    apply(100, -50, 7, 0, -1, 391, -195);

    repeat (2) apply(511, 511, 511, 511, 511, SAT ? 511 : -28, SAT ? 511 : -28);
    repeat (2) apply(-512, -512, -512, -512, -512, SAT ? -512 : 0, SAT ? -512 : 0);
    apply(511, 511, 511, 0, 0, SAT ? 511 : 493, SAT ? 511 : -6);

    repeat (6) apply(2, -10, 3, 4, -13, 63, -99);

    // Mid-cycle reset with results in flight: Z must clear without a clock edge.
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset", Z, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 check("reset_hold", Z, '0);

    apply(2, -10, 3, 4, -13, 63, -99, 1'b1);
    repeat (4) apply(2, -10, 3, 4, -13, 63, -99);
    repeat (5) apply(0, 0, 0, 0, 0, 0, 0);
    repeat (6) @(negedge clk);

    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d results left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
